// File: rtl/scan_chain_reg.sv
// scan_chain_reg: WIDTH-bit scan register with a capture/shift stage, a separate
// update stage, and a saturating shift counter with a word-loaded flag.
module scan_chain_reg #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [1:0]                   mode,
  input  logic [WIDTH-1:0]             d,
  input  logic                         scan_in,
  output logic                         scan_out,
  output logic [WIDTH-1:0]             q,
  output logic [WIDTH-1:0]             qbar,
  output logic [$clog2(WIDTH+1)-1:0]   shift_cnt,
  output logic                         shift_done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [1:0] MODE_HOLD    = 2'b00;
  localparam logic [1:0] MODE_CAPTURE = 2'b01;
  localparam logic [1:0] MODE_SHIFT   = 2'b10;
  localparam logic [1:0] MODE_UPDATE  = 2'b11;

  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  logic [WIDTH-1:0] r_cap;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_qbar;
  logic [CW-1:0]    r_cnt;
  logic             r_done;

  logic [WIDTH-1:0] w_cap_shifted;
  logic [CW-1:0]    w_cnt_inc;
  logic [WIDTH-1:0] w_cap_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] w_qbar_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_done_nxt;

  // Serial shift: LSB-first in, so the MSB is the bit leaving the chain.
  generate
    if (WIDTH == 1) begin : g_shift_w1
      assign w_cap_shifted = scan_in;
    end else begin : g_shift_wn
      assign w_cap_shifted = {r_cap[WIDTH-2:0], scan_in};
    end
  endgenerate

  // Shift counter increment, holding at WIDTH once a full word is in.
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CW'(1);

  // Next-state selection by mode; reset overrides every mode.
  always_comb begin
    w_cap_nxt  = r_cap;
    w_q_nxt    = r_q;
    w_qbar_nxt = r_qbar;
    w_cnt_nxt  = r_cnt;
    w_done_nxt = r_done;
    if (!rst) begin
      w_cap_nxt  = RESET_VAL;
      w_q_nxt    = RESET_VAL;
      w_qbar_nxt = ~RESET_VAL;
      w_cnt_nxt  = '0;
      w_done_nxt = 1'b0;
    end else begin
      case (mode)
        MODE_CAPTURE: begin
          w_cap_nxt  = d;
          w_cnt_nxt  = '0;
          w_done_nxt = 1'b0;
        end
        MODE_SHIFT: begin
          w_cap_nxt  = w_cap_shifted;
          w_cnt_nxt  = w_cnt_inc;
          w_done_nxt = (w_cnt_inc == CNT_MAX);
        end
        MODE_UPDATE: begin
          w_q_nxt    = r_cap;
          w_qbar_nxt = ~r_cap;
          w_cnt_nxt  = '0;
          w_done_nxt = 1'b0;
        end
        MODE_HOLD: ;
        default: ;
      endcase
    end
  end

  // State register; synchronous reset is already folded into the next-state logic.
  always_ff @(posedge clk) begin
    r_cap  <= w_cap_nxt;
    r_q    <= w_q_nxt;
    r_qbar <= w_qbar_nxt;
    r_cnt  <= w_cnt_nxt;
    r_done <= w_done_nxt;
  end

  assign scan_out   = r_cap[WIDTH-1];
  assign q          = r_q;
  assign qbar       = r_qbar;
  assign shift_cnt  = r_cnt;
  assign shift_done = r_done;

endmodule

// File: tb/tb_scan_chain_reg.sv
// Directed bench for scan_chain_reg: an 8-bit instance checked against a bench
// model through a scoreboard, plus a 1-bit instance checked directly.
module tb_scan_chain_reg;

  localparam logic [1:0] HOLD = 2'b00;
  localparam logic [1:0] CAP  = 2'b01;
  localparam logic [1:0] SHF  = 2'b10;
  localparam logic [1:0] UPD  = 2'b11;

  typedef struct {
    logic [7:0] q;
    logic [7:0] qbar;
    logic [3:0] cnt;
    logic       done;
    logic       so;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [1:0] mode;
  logic [7:0] d;
  logic       scan_in;
  logic       scan_out;
  logic [7:0] q;
  logic [7:0] qbar;
  logic [3:0] shift_cnt;
  logic       shift_done;

  logic       rst1;
  logic [1:0] mode1;
  logic [0:0] d1;
  logic       scan_in1;
  logic       scan_out1;
  logic [0:0] q1;
  logic [0:0] qbar1;
  logic [0:0] shift_cnt1;
  logic       shift_done1;

  int checks   = 0;
  int failures = 0;

  exp_t sb[$];

  // Bench model of the 8-bit instance
  logic [7:0] m_cap;
  logic [7:0] m_q;
  int         m_cnt;
  logic       m_valid = 1'b0;

  logic [7:0] pat;
  logic       hist[0:15];

  scan_chain_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
    .clk(clk), .rst(rst), .mode(mode), .d(d), .scan_in(scan_in),
    .scan_out(scan_out), .q(q), .qbar(qbar),
    .shift_cnt(shift_cnt), .shift_done(shift_done)
  );

  scan_chain_reg #(.WIDTH(1), .RESET_VAL(1'b0)) dut1 (
    .clk(clk), .rst(rst1), .mode(mode1), .d(d1), .scan_in(scan_in1),
    .scan_out(scan_out1), .q(q1), .qbar(qbar1),
    .shift_cnt(shift_cnt1), .shift_done(shift_done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model(input logic [1:0] md, input logic [7:0] dv, input logic si, input logic rv);
    if (!rv) begin
      m_cap = 8'h00; m_q = 8'h00; m_cnt = 0; m_valid = 1'b1;
    end else if (md == CAP) begin
      m_cap = dv; m_cnt = 0;
    end else if (md == SHF) begin
      m_cap = (m_cap << 1) | {7'd0, si};
      if (m_cnt < 8) m_cnt = m_cnt + 1;
    end else if (md == UPD) begin
      m_q = m_cap; m_cnt = 0;
    end
  endtask

  // One clock of stimulus: drive at negedge, check nothing moves before the edge,
  // queue the model's prediction, then compare just after the rising edge.
  task automatic step(input logic [1:0] md, input logic [7:0] dv, input logic si, input logic rv);
    exp_t e;
    @(negedge clk);
    mode = md; d = dv; scan_in = si; rst = rv;
    #1;
    if (m_valid) begin
      chk("q_stable_pre_edge", 32'(q), 32'(m_q));
      chk("cnt_stable_pre_edge", 32'(shift_cnt), 32'(m_cnt));
      chk("scan_out_pre_edge", 32'(scan_out), 32'(m_cap[7]));
    end
    model(md, dv, si, rv);
    e.q    = m_q;
    e.qbar = ~m_q;
    e.cnt  = 4'(m_cnt);
    e.done = (m_cnt == 8);
    e.so   = m_cap[7];
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("sb_q", 32'(q), 32'(e.q));
    chk("sb_qbar", 32'(qbar), 32'(e.qbar));
    chk("sb_cnt", 32'(shift_cnt), 32'(e.cnt));
    chk("sb_done", 32'(shift_done), 32'(e.done));
    chk("sb_scan_out", 32'(scan_out), 32'(e.so));
  endtask

  initial begin
    rst = 1'b0; mode = SHF; d = 8'h00; scan_in = 1'b1;
    rst1 = 1'b0; mode1 = HOLD; d1 = 1'b0; scan_in1 = 1'b0;

    // 1. Reset while SHIFT with scan_in=1 is requested
    step(SHF, 8'h00, 1'b1, 1'b0);
    step(SHF, 8'h00, 1'b1, 1'b0);
    chk("rst_q", 32'(q), 32'h00);
    chk("rst_qbar", 32'(qbar), 32'hFF);
    chk("rst_scan_out", 32'(scan_out), 32'h0);
    chk("rst_cnt", 32'(shift_cnt), 32'h0);
    chk("rst_done", 32'(shift_done), 32'h0);
    @(negedge clk); rst1 = 1'b1;

    // 2. Capture 0xA5 then shift it out MSB-first
    step(CAP, 8'hA5, 1'b0, 1'b1);
    pat = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      chk("shiftout_bit", 32'(scan_out), 32'(pat[7-i]));
      chk("shiftout_done_early", 32'(shift_done), 32'h0);
      step(SHF, 8'h00, 1'b0, 1'b1);
    end
    chk("shiftout_q", 32'(q), 32'h00);
    chk("shiftout_cnt", 32'(shift_cnt), 32'h8);
    chk("shiftout_done", 32'(shift_done), 32'h1);

    // 3. Shift in 0x3C MSB-first, update twice
    pat = 8'h3C;
    for (int i = 7; i >= 0; i--) step(SHF, 8'h00, pat[i], 1'b1);
    step(UPD, 8'h00, 1'b0, 1'b1);
    chk("upd_q", 32'(q), 32'h3C);
    chk("upd_qbar", 32'(qbar), 32'hC3);
    chk("upd_cnt", 32'(shift_cnt), 32'h0);
    chk("upd_done", 32'(shift_done), 32'h0);
    step(UPD, 8'hFF, 1'b1, 1'b1);
    chk("upd2_q", 32'(q), 32'h3C);

    // 4. Three shifts, hold five edges, five more shifts of 0x96
    pat = 8'h96;
    for (int i = 7; i >= 5; i--) step(SHF, 8'h00, pat[i], 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(HOLD, 8'hFF, 1'b1, 1'b1);
      chk("hold_cnt", 32'(shift_cnt), 32'h3);
      chk("hold_q", 32'(q), 32'h3C);
    end
    for (int i = 4; i >= 0; i--) step(SHF, 8'h00, pat[i], 1'b1);
    chk("hold_resume_cnt", 32'(shift_cnt), 32'h8);
    chk("hold_resume_done", 32'(shift_done), 32'h1);
    step(UPD, 8'h00, 1'b0, 1'b1);
    chk("hold_data_q", 32'(q), 32'h96);

    // 5. Saturation over 11 shifts with random serial data
    step(CAP, 8'h00, 1'b0, 1'b1);
    for (int n = 1; n <= 11; n++) begin
      hist[n] = 1'($urandom_range(1, 0));
      step(SHF, 8'h00, hist[n], 1'b1);
      if (n >= 8) begin
        chk("sat_cnt", 32'(shift_cnt), 32'h8);
        chk("sat_done", 32'(shift_done), 32'h1);
        chk("sat_scan_out", 32'(scan_out), 32'(hist[n-7]));
      end
    end

    // 6. Reset mid-operation with q=0x3C and four shifts done
    step(CAP, 8'h3C, 1'b0, 1'b1);
    step(UPD, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(SHF, 8'h00, 1'b1, 1'b1);
    chk("mid_cnt", 32'(shift_cnt), 32'h4);
    step(SHF, 8'h00, 1'b1, 1'b0);
    chk("midrst_q", 32'(q), 32'h00);
    chk("midrst_qbar", 32'(qbar), 32'hFF);
    chk("midrst_cnt", 32'(shift_cnt), 32'h0);
    chk("midrst_done", 32'(shift_done), 32'h0);
    chk("midrst_scan_out", 32'(scan_out), 32'h0);

    // WIDTH=1 instance
    chk("w1_rst_scan_out", 32'(scan_out1), 32'h0);
    chk("w1_rst_qbar", 32'(qbar1), 32'h1);
    @(negedge clk); mode1 = SHF; scan_in1 = 1'b1;
    @(posedge clk); #1;
    chk("w1_scan_out", 32'(scan_out1), 32'h1);
    chk("w1_done", 32'(shift_done1), 32'h1);
    chk("w1_cnt", 32'(shift_cnt1), 32'h1);
    chk("w1_q_unchanged", 32'(q1), 32'h0);
    @(negedge clk); mode1 = UPD; scan_in1 = 1'b0;
    @(posedge clk); #1;
    chk("w1_upd_q", 32'(q1), 32'h1);
    chk("w1_upd_qbar", 32'(qbar1), 32'h0);
    chk("w1_upd_done", 32'(shift_done1), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scan_chain_reg.md
Name: scan_chain_reg

Overview:
- Parametrised multi-bit scan register: a WIDTH-bit capture/shift stage plus a separate WIDTH-bit update (output) stage.
- Extends the single-bit scan flip-flop with four modes: hold, parallel capture, serial shift and update.
- Adds a shift counter and a chain-loaded flag so the test controller knows when a full word has been shifted.
- Instances are chained, scan_out to scan_in, to form test data registers.

Parameters:
- WIDTH, 8: number of bits in the capture and update stages; legal range is 1 or more.
- RESET_VAL, all zeros (WIDTH bits): reset value of the capture and update stages.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-low reset.
- mode  input  2  operation select: 00 HOLD, 01 CAPTURE, 10 SHIFT, 11 UPDATE.
- d  input  WIDTH  parallel capture data.
- scan_in  input  1  serial data in; enters bit 0.
- scan_out  output  1  serial data out; equals capture-stage bit WIDTH-1.
- q  output  WIDTH  update-stage contents.
- qbar  output  WIDTH  bitwise complement of q.
- shift_cnt  output  CW  shifts since the last CAPTURE or UPDATE, where CW = clog2(WIDTH+1).
- shift_done  output  1  high once WIDTH shifts have occurred.

Behaviour:
- Clock and reset: single clock clk; all state changes on the rising edge of clk.
- Reset (already decided): rst is synchronous and active-low. rst=0 at a rising edge has no effect between edges.
  - Reset takes priority over mode.
  - Reset state: cap=RESET_VAL, q=RESET_VAL, qbar=~RESET_VAL, shift_cnt=0, shift_done=0.
  - scan_out therefore resets to RESET_VAL[WIDTH-1].
- State: internal capture stage cap[WIDTH-1:0]; update stage drives q.
  - q and qbar are both registered and always exact complements.
- scan_out = cap[WIDTH-1], combinational from cap. The bit presented is the one that leaves on the next SHIFT edge.
- HOLD (00): cap, q, qbar, shift_cnt and shift_done all retain their values.
- CAPTURE (01):
  - cap <= d; shift_cnt <= 0; shift_done <= 0.
  - q and qbar unchanged.
- SHIFT (10):
  - cap <= {cap[WIDTH-2:0], scan_in}. For WIDTH=1, cap <= scan_in.
  - shift_cnt <= shift_cnt+1, saturating at WIDTH.
  - shift_done <= 1 on the edge where shift_cnt becomes WIDTH, and stays 1 while saturated.
  - Shifting continues after saturation; data keeps moving.
  - q and qbar unchanged.
- UPDATE (11):
  - q <= cap; qbar <= ~cap; shift_cnt <= 0; shift_done <= 0.
  - cap unchanged, so UPDATE can be repeated without re-shifting.
- Latency: every mode acts in one cycle. q changes only on UPDATE or reset; shifting never glitches q.
- Ordering: MSB-first out, LSB-first in. After WIDTH shifts, the first bit shifted in sits at cap[WIDTH-1].
- Mode changes mid-shift: no restrictions.
  - HOLD pauses the count.
  - CAPTURE or UPDATE restarts the count.
- All inputs are assumed synchronous to clk. There is no X-propagation masking.

Test Plan:
1. Reset: mode=10, scan_in=1, rst=0 for 2 edges with WIDTH=8, RESET_VAL=0 -> q=0x00, qbar=0xFF, scan_out=0, shift_cnt=0, shift_done=0. Lowering rst between edges changes nothing until the next edge.
2. Capture and shift-out: d=0xA5, mode=01 for 1 edge, then mode=10 with scan_in=0 for 8 edges.
   - scan_out before each edge reads 1,0,1,0,0,1,0,1.
   - q stays 0x00.
   - shift_cnt=8 and shift_done=1 after the 8th edge, not before.
3. Shift-in and update: shift 0x3C MSB-first over 8 edges, then mode=11 -> q=0x3C, qbar=0xC3, shift_cnt=0, shift_done=0. Cap is still 0x3C; a second UPDATE leaves q=0x3C.
4. Hold mid-shift: 3 shifts, then mode=00 for 5 edges.
   - cap, q and shift_cnt=3 are frozen.
   - 5 more shifts give shift_cnt=8 and shift_done=1, with correct data.
5. Saturation: 11 consecutive shifts after CAPTURE -> shift_cnt stays 8 and shift_done stays 1 from edge 8. scan_out equals the scan_in value applied 8 edges earlier.
6. Reset mid-operation, plus WIDTH=1:
   - With q=0x3C and 4 shifts done, rst=0 for 1 edge -> full reset state.
   - Separate WIDTH=1 instance: SHIFT scan_in=1 -> scan_out=1, shift_done=1 after 1 edge.
